zap_divider: RTL and testbench

- Iterative 32-bit integer divider for the ZAP execute stage.
- It is the inverse-direction companion to the multi-cycle multiply unit and implements UDIV/SDIV semantics, returning both quotient and remainder.
- Radix-2 restoring division with one quotient bit per cycle.
- Uses the same busy/stall/clear handshake as the multiply unit, so the ALU sequences both units identically.

---
 rtl/zap_divider.sv | 175 +++++++++++++++++
 tb/tb_zap_divider.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/zap_divider.sv
// zap_divider - iterative 32-bit integer divider for the ZAP execute stage.
//
// Radix-2 restoring division, one quotient bit per cycle, UDIV/SDIV
// semantics with both quotient and remainder. It shares the busy/stall/clear
// handshake of the multi-cycle multiply unit, so the ALU can sequence both
// units identically.
//
// Ports:
//   i_clk                   clock
//   i_reset                 synchronous active-high reset
//   i_clear_from_writeback  flush, aborts any operation (beats stall)
//   i_data_stall            freeze all state
//   i_clear_from_alu        flush from ALU, aborts any operation (loses to stall)
//   i_start                 divide request, sampled only in IDLE
//   i_signed                1 = SDIV, 0 = UDIV, captured with i_start
//   i_dividend, i_divisor   operands, captured with i_start
//   o_quotient, o_remainder registered results, valid with o_done, held until
//                           the next result is produced
//   o_busy                  ALU must hold issue while high
//   o_done                  one-cycle result-valid pulse
//   o_div_by_zero           divisor was zero, valid with o_done
//
// State | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for i_start; o_busy follows i_start combinationally
// SETUP | form operand magnitudes and result signs; trap divide-by-zero
// ITER  | one restoring-division step per cycle, 32 cycles
// FIXUP | apply signs and load the result registers
// DONE  | o_done pulse; a start here is ignored
module zap_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clear_from_writeback,
  input  logic             i_data_stall,
  input  logic             i_clear_from_alu,
  input  logic             i_start,
  input  logic             i_signed,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_div_by_zero
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_ITER  = 3'd2;
  localparam logic [2:0] S_FIXUP = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             signed_q;
  logic [WIDTH-1:0] dvd_raw;
  logic [WIDTH-1:0] dvs_raw;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH-1:0] q_acc;
  // The partial remainder is always below the divisor, so WIDTH bits hold it;
  // the extra bit only appears in the shifted trial value below.
  logic [WIDTH-1:0] r_acc;
  logic             neg_q;
  logic             neg_r;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] rem_q;
  logic             dbz_q;

  logic [WIDTH-1:0] dvd_abs;
  logic [WIDTH-1:0] dvs_abs;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  // Negating 0x80000000 yields 0x80000000, which is the correct unsigned
  // magnitude, so the signed-overflow case needs no special handling.
  assign dvd_abs = (signed_q && dvd_raw[WIDTH-1]) ? -dvd_raw : dvd_raw;
  assign dvs_abs = (signed_q && dvs_raw[WIDTH-1]) ? -dvs_raw : dvs_raw;
  assign shifted = {r_acc, q_acc[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvs_mag};

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      signed_q <= 1'b0;
      dvd_raw  <= '0;
      dvs_raw  <= '0;
      dvs_mag  <= '0;
      q_acc    <= '0;
      r_acc    <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      quot_q   <= '0;
      rem_q    <= '0;
      dbz_q    <= 1'b0;
    end else if (i_clear_from_writeback) begin
      state <= S_IDLE;
    end else if (!i_data_stall) begin
      if (i_clear_from_alu) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (i_start) begin
              signed_q <= i_signed;
              dvd_raw  <= i_dividend;
              dvs_raw  <= i_divisor;
              state    <= S_SETUP;
            end
          end
          S_SETUP: begin
            neg_q   <= signed_q & (dvd_raw[WIDTH-1] ^ dvs_raw[WIDTH-1]);
            neg_r   <= signed_q & dvd_raw[WIDTH-1];
            r_acc   <= '0;
            q_acc   <= dvd_abs;
            dvs_mag <= dvs_abs;
            cnt     <= CNT_W'(WIDTH - 1);
            if (dvs_raw == '0) begin
              dbz_q  <= 1'b1;
              quot_q <= '0;
              rem_q  <= dvd_raw;
              state  <= S_DONE;
            end else begin
              dbz_q <= 1'b0;
              state <= S_ITER;
            end
          end
          S_ITER: begin
            if (!trial[WIDTH]) begin
              r_acc <= trial[WIDTH-1:0];
              q_acc <= {q_acc[WIDTH-2:0], 1'b1};
            end else begin
              r_acc <= shifted[WIDTH-1:0];
              q_acc <= {q_acc[WIDTH-2:0], 1'b0};
            end
            if (cnt == '0) begin
              state <= S_FIXUP;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          S_FIXUP: begin
            quot_q <= neg_q ? -q_acc : q_acc;
            rem_q  <= neg_r ? -r_acc : r_acc;
            state  <= S_DONE;
          end
          S_DONE: begin
            state <= S_IDLE;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

  always_comb begin
    o_busy = 1'b0;
    case (state)
      S_IDLE:                   o_busy = i_start;
      S_SETUP, S_ITER, S_FIXUP: o_busy = 1'b1;
      default:                  o_busy = 1'b0;
    endcase
  end

  assign o_done        = (state == S_DONE);
  assign o_quotient    = quot_q;
  assign o_remainder   = rem_q;
  assign o_div_by_zero = dbz_q;

endmodule

// File: tb/tb_zap_divider.sv
// tb_zap_divider - directed-vector bench for zap_divider.
// The driver pushes hand-computed results (and the cycle o_done is due) into
// a queue; an independent monitor pops and compares on every o_done pulse.
module tb_zap_divider;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_clear_from_writeback;
  logic        i_data_stall;
  logic        i_clear_from_alu;
  logic        i_start;
  logic        i_signed;
  logic [31:0] i_dividend;
  logic [31:0] i_divisor;
  logic [31:0] o_quotient;
  logic [31:0] o_remainder;
  logic        o_busy;
  logic        o_done;
  logic        o_div_by_zero;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc    = 0;
  int   n_vec  = 0;
  int   n_mism = 0;

  zap_divider #(.WIDTH(32), .CNT_W(6)) dut (
    .i_clk                 (i_clk),
    .i_reset               (i_reset),
    .i_clear_from_writeback(i_clear_from_writeback),
    .i_data_stall          (i_data_stall),
    .i_clear_from_alu      (i_clear_from_alu),
    .i_start               (i_start),
    .i_signed              (i_signed),
    .i_dividend            (i_dividend),
    .i_divisor             (i_divisor),
    .o_quotient            (o_quotient),
    .o_remainder           (o_remainder),
    .o_busy                (o_busy),
    .o_done                (o_done),
    .o_div_by_zero         (o_div_by_zero)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mism++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every o_done pulse must match the oldest expected result.
  always @(negedge i_clk) begin
    if (!i_reset && o_done) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_mism++;
        $display("FAIL unexpected_done: got o_done=1, expected none (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("quotient",    o_quotient,    e.q);
        check("remainder",   o_remainder,   e.r);
        check("div_by_zero", {31'd0, o_div_by_zero}, {31'd0, e.dbz});
        check("done_cycle",  cyc,           e.cyc);
        check("busy_at_done", {31'd0, o_busy}, 32'd0);
      end
    end
  end

  // Called at a negedge; the start is accepted on the next posedge.
  task automatic issue(input logic sgn, input logic [31:0] dvd, input logic [31:0] dvs,
                       input logic [31:0] eq, input logic [31:0] er, input logic edbz,
                       input int lat, input bit expect_done);
    exp_t e;
    i_signed   = sgn;
    i_dividend = dvd;
    i_divisor  = dvs;
    i_start    = 1'b1;
    #1;
    check("busy_on_start", {31'd0, o_busy}, 32'd1);
    if (expect_done) begin
      e.q = eq; e.r = er; e.dbz = edbz; e.cyc = cyc + lat;
      exp_q.push_back(e);
    end
    @(negedge i_clk);
    i_start    = 1'b0;
    i_signed   = ~sgn;
    i_dividend = ~dvd;
    i_divisor  = 32'h5A5A_5A5A;
    check("busy_in_setup", {31'd0, o_busy}, 32'd1);
  endtask

  task automatic wait_for_done();
    int n = 0;
    while (!o_done && n < 200) begin
      @(negedge i_clk);
      n++;
    end
    if (!o_done) begin
      n_vec++;
      n_mism++;
      $display("FAIL done_timeout: got no o_done, expected one within 200 cycles");
    end
  endtask

  task automatic wait_done();
    wait_for_done();
    @(negedge i_clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_q"},    o_quotient,  32'd0);
    check({tag, "_r"},    o_remainder, 32'd0);
    check({tag, "_done"}, {31'd0, o_done},        32'd0);
    check({tag, "_busy"}, {31'd0, o_busy},        32'd0);
    check({tag, "_dbz"},  {31'd0, o_div_by_zero}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected completion before 100000 ns");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    i_reset = 1'b1;
    i_clear_from_writeback = 1'b0;
    i_data_stall = 1'b0;
    i_clear_from_alu = 1'b0;
    i_start = 1'b0;
    i_signed = 1'b0;
    i_dividend = '0;
    i_divisor = '0;
    repeat (3) @(negedge i_clk);
    check_reset_outputs("reset");
    i_reset = 1'b0;
    @(negedge i_clk);

    // Basic unsigned and signed vectors.
    issue(1'b0, 32'd100,      32'd7,        32'h0000_000E, 32'h0000_0002, 1'b0, 35, 1); wait_done();
    issue(1'b1, 32'hFFFF_FF9C, 32'd7,       32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 35, 1); wait_done();
    issue(1'b1, 32'd100,      32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'h0000_0002, 1'b0, 35, 1); wait_done();
    issue(1'b0, 32'h1234_5678, 32'd0,       32'h0000_0000, 32'h1234_5678, 1'b1, 2,  1); wait_done();
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b0, 35, 1); wait_done();
    issue(1'b0, 32'hFFFF_FFFF, 32'd1,       32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 35, 1); wait_done();
    issue(1'b1, 32'd7,        32'hFFFF_FF9C, 32'h0000_0000, 32'h0000_0007, 1'b0, 35, 1); wait_done();
    issue(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 1'b0, 35, 1); wait_done();
    issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 32'h0000_0001, 1'b0, 35, 1); wait_done();
    issue(1'b1, 32'hFFFF_FFFB, 32'd0,       32'h0000_0000, 32'hFFFF_FFFB, 1'b1, 2,  1); wait_done();

    // Five stalled cycles in ITER push o_done from 35 to 40.
    issue(1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 40, 1);
    repeat (3) @(negedge i_clk);
    i_data_stall = 1'b1;
    repeat (5) @(negedge i_clk);
    i_data_stall = 1'b0;
    wait_done();

    // ALU clear at cycle 10 aborts; restart at cycle 12 finishes at cycle 47.
    issue(1'b0, 32'd50, 32'd5, 32'd0, 32'd0, 1'b0, 35, 0);
    repeat (9) @(negedge i_clk);
    i_clear_from_alu = 1'b1;
    @(negedge i_clk);
    i_clear_from_alu = 1'b0;
    #1;
    check("clear_alu_busy", {31'd0, o_busy}, 32'd0);
    check("clear_keeps_q",  o_quotient, 32'd333);
    @(negedge i_clk);
    issue(1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 1'b0, 35, 1);
    wait_done();

    // Writeback clear wins over a simultaneous stall.
    issue(1'b1, 32'hFFFF_FFEC, 32'd3, 32'd0, 32'd0, 1'b0, 35, 0);
    repeat (4) @(negedge i_clk);
    i_data_stall = 1'b1;
    i_clear_from_writeback = 1'b1;
    @(negedge i_clk);
    i_data_stall = 1'b0;
    i_clear_from_writeback = 1'b0;
    #1;
    check("clear_wb_busy", {31'd0, o_busy}, 32'd0);
    @(negedge i_clk);
    check("clear_wb_idle", {31'd0, o_busy}, 32'd0);
    issue(1'b1, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, 32'hFFFF_FFFE, 1'b0, 35, 1);
    wait_done();

    // Reset in FIXUP (cycle 34) after a div-by-zero result left nonzero outputs.
    issue(1'b0, 32'hCAFE_0001, 32'd0, 32'd0, 32'hCAFE_0001, 1'b1, 2, 1);
    wait_done();
    s = cyc;
    issue(1'b0, 32'd100, 32'd7, 32'd0, 32'd0, 1'b0, 35, 0);
    while (cyc < s + 34) @(negedge i_clk);
    i_reset = 1'b1;
    @(negedge i_clk);
    check_reset_outputs("fixup_reset");
    i_reset = 1'b0;
    @(negedge i_clk);

    // A start pulse during DONE is ignored.
    issue(1'b0, 32'd9, 32'd2, 32'd4, 32'd1, 1'b0, 35, 1);
    wait_for_done();
    i_start = 1'b1;
    i_divisor = 32'd0;
    @(negedge i_clk);
    i_start = 1'b0;
    #1;
    check("done_start_ignored", {31'd0, o_busy}, 32'd0);
    repeat (40) @(negedge i_clk);

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mism);
    $finish;
  end

endmodule
